// File: rtl/regfile_mp.sv
// regfile_mp: multi-port register file with two write ports, two registered read ports, optional write-to-read bypass and a per-register pending scoreboard.
// Ports: clk, rst (async, active-high); rd_en, ra, rb -> bus_a, bus_b, pend_a, pend_b (registered read data and pending flags);
// we0/rw0/bus_w0 and we1/rw1/bus_w1 (write ports, port 0 wins on a shared address); mark_en/mark_addr (set pending);
// collide (one-cycle pulse after both write ports hit the same address).
module regfile_mp #(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 4,
    parameter int ZERO_R0 = 0,
    parameter int BYPASS  = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] ra,
    input  logic [ADDR_W-1:0] rb,
    output logic [DATA_W-1:0] bus_a,
    output logic [DATA_W-1:0] bus_b,
    output logic              pend_a,
    output logic              pend_b,
    input  logic              we0,
    input  logic [ADDR_W-1:0] rw0,
    input  logic [DATA_W-1:0] bus_w0,
    input  logic              we1,
    input  logic [ADDR_W-1:0] rw1,
    input  logic [DATA_W-1:0] bus_w1,
    input  logic              mark_en,
    input  logic [ADDR_W-1:0] mark_addr,
    output logic              collide
);
    localparam int NREGS = 1 << ADDR_W;

    logic [NREGS-1:0][DATA_W-1:0] regs_q, regs_d;
    logic [NREGS-1:0]             pend_q, pend_d;
    logic [DATA_W-1:0]            bus_a_q, bus_a_d, bus_b_q, bus_b_d;
    logic                         pend_a_q, pend_a_d, pend_b_q, pend_b_d;
    logic                         collide_q, collide_d;
    logic                         wr0_ok, wr1_ok, mark_ok;

    // Register 0 is hard-wired to zero when ZERO_R0 is set, so writes and marks to it are dropped.
    assign wr0_ok  = we0 && !(ZERO_R0 != 0 && rw0 == '0);
    assign wr1_ok  = we1 && !(ZERO_R0 != 0 && rw1 == '0);
    assign mark_ok = mark_en && !(ZERO_R0 != 0 && mark_addr == '0);

    always_comb begin
        regs_d    = regs_q;
        pend_d    = pend_q;
        // Port 1 is applied first so port 0 overrides it on a shared address.
        if (wr1_ok) begin
            regs_d[rw1] = bus_w1;
            pend_d[rw1] = 1'b0;
        end
        if (wr0_ok) begin
            regs_d[rw0] = bus_w0;
            pend_d[rw0] = 1'b0;
        end
        // A mark names a newly issued producer, so it outranks a retiring write.
        if (mark_ok)
            pend_d[mark_addr] = 1'b1;
        // Bypass reads the post-edge image; otherwise the pre-edge state.
        bus_a_d   = rd_en ? (BYPASS != 0 ? regs_d[ra] : regs_q[ra]) : bus_a_q;
        bus_b_d   = rd_en ? (BYPASS != 0 ? regs_d[rb] : regs_q[rb]) : bus_b_q;
        pend_a_d  = rd_en ? (BYPASS != 0 ? pend_d[ra] : pend_q[ra]) : pend_a_q;
        pend_b_d  = rd_en ? (BYPASS != 0 ? pend_d[rb] : pend_q[rb]) : pend_b_q;
        collide_d = we0 && we1 && (rw0 == rw1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            regs_q    <= '0;
            pend_q    <= '0;
            bus_a_q   <= '0;
            bus_b_q   <= '0;
            pend_a_q  <= 1'b0;
            pend_b_q  <= 1'b0;
            collide_q <= 1'b0;
        end else begin
            regs_q    <= regs_d;
            pend_q    <= pend_d;
            bus_a_q   <= bus_a_d;
            bus_b_q   <= bus_b_d;
            pend_a_q  <= pend_a_d;
            pend_b_q  <= pend_b_d;
            collide_q <= collide_d;
        end
    end

    assign bus_a   = bus_a_q;
    assign bus_b   = bus_b_q;
    assign pend_a  = pend_a_q;
    assign pend_b  = pend_b_q;
    assign collide = collide_q;
endmodule

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp: directed bench driving a bypassing instance and a non-bypassing zero-r0 instance with shared stimulus.
module tb_regfile_mp;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rd_en = 1'b0;
    logic [3:0]  ra = '0, rb = '0, rw0 = '0, rw1 = '0, mark_addr = '0;
    logic        we0 = 1'b0, we1 = 1'b0, mark_en = 1'b0;
    logic [31:0] bus_w0 = '0, bus_w1 = '0;
    logic [31:0] a_y, b_y, a_z, b_z;
    logic        pa_y, pb_y, pa_z, pb_z, col_y, col_z;
    int          passed = 0, total = 0;

    always #5 clk = ~clk;

    regfile_mp #(.DATA_W(32), .ADDR_W(4), .ZERO_R0(0), .BYPASS(1)) dut_y (
        .clk(clk), .rst(rst), .rd_en(rd_en), .ra(ra), .rb(rb),
        .bus_a(a_y), .bus_b(b_y), .pend_a(pa_y), .pend_b(pb_y),
        .we0(we0), .rw0(rw0), .bus_w0(bus_w0), .we1(we1), .rw1(rw1), .bus_w1(bus_w1),
        .mark_en(mark_en), .mark_addr(mark_addr), .collide(col_y));

    regfile_mp #(.DATA_W(32), .ADDR_W(4), .ZERO_R0(1), .BYPASS(0)) dut_z (
        .clk(clk), .rst(rst), .rd_en(rd_en), .ra(ra), .rb(rb),
        .bus_a(a_z), .bus_b(b_z), .pend_a(pa_z), .pend_b(pb_z),
        .we0(we0), .rw0(rw0), .bus_w0(bus_w0), .we1(we1), .rw1(rw1), .bus_w1(bus_w1),
        .mark_en(mark_en), .mark_addr(mark_addr), .collide(col_z));

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        we0 = 1'b0;
        we1 = 1'b0;
        mark_en = 1'b0;
    endtask

    task automatic test_reset();
        step();
        step();
        total++;
        if ({a_y, b_y, pa_y, pb_y, col_y, a_z, b_z, pa_z, pb_z, col_z} !== '0)
            $display("FAIL reset_outputs: got y=%h/%h/%b%b%b z=%h/%h/%b%b%b want all 0",
                     a_y, b_y, pa_y, pb_y, col_y, a_z, b_z, pa_z, pb_z, col_z);
        else passed++;
        rst = 1'b0;
    endtask

    task automatic test_bypass();
        rd_en = 1'b1; ra = 4'd3;
        we0 = 1'b1; rw0 = 4'd3; bus_w0 = 32'hDEADBEEF;
        step();
        total++;
        if (a_y !== 32'hDEADBEEF) $display("FAIL bypass_same_cycle: got %h want deadbeef", a_y);
        else passed++;
        total++;
        if (a_z !== 32'h0) $display("FAIL nobypass_same_cycle: got %h want 0", a_z);
        else passed++;
        idle();
        step();
        total++;
        if (a_z !== 32'hDEADBEEF || a_y !== 32'hDEADBEEF)
            $display("FAIL nobypass_next_cycle: got y=%h z=%h want deadbeef", a_y, a_z);
        else passed++;
    endtask

    task automatic test_collide();
        ra = 4'd5;
        we0 = 1'b1; rw0 = 4'd5; bus_w0 = 32'h11;
        we1 = 1'b1; rw1 = 4'd5; bus_w1 = 32'h22;
        step();
        total++;
        if (col_y !== 1'b1 || col_z !== 1'b1) $display("FAIL collide_pulse: got y=%b z=%b want 1", col_y, col_z);
        else passed++;
        total++;
        if (a_y !== 32'h11 || a_z !== 32'h0) $display("FAIL collide_bypass_data: got y=%h z=%h want 11/0", a_y, a_z);
        else passed++;
        idle();
        step();
        total++;
        if (col_y !== 1'b0 || col_z !== 1'b0) $display("FAIL collide_one_cycle: got y=%b z=%b want 0", col_y, col_z);
        else passed++;
        total++;
        if (a_y !== 32'h11 || a_z !== 32'h11) $display("FAIL collide_port0_wins: got y=%h z=%h want 11", a_y, a_z);
        else passed++;
        ra = 4'd5; rb = 4'd6;
        we0 = 1'b1; rw0 = 4'd5; bus_w0 = 32'h11;
        we1 = 1'b1; rw1 = 4'd6; bus_w1 = 32'h22;
        step();
        total++;
        if (col_y !== 1'b0 || col_z !== 1'b0) $display("FAIL no_collide: got y=%b z=%b want 0", col_y, col_z);
        else passed++;
        total++;
        if (a_y !== 32'h11 || b_y !== 32'h22) $display("FAIL dual_write_bypass: got %h/%h want 11/22", a_y, b_y);
        else passed++;
        idle();
        step();
        total++;
        if (a_z !== 32'h11 || b_z !== 32'h22) $display("FAIL dual_write_stored: got %h/%h want 11/22", a_z, b_z);
        else passed++;
    endtask

    task automatic test_scoreboard();
        rb = 4'd7;
        mark_en = 1'b1; mark_addr = 4'd7;
        step();
        total++;
        if (pb_y !== 1'b1 || pb_z !== 1'b0) $display("FAIL mark_visibility: got y=%b z=%b want 1/0", pb_y, pb_z);
        else passed++;
        idle();
        step();
        total++;
        if (pb_y !== 1'b1 || pb_z !== 1'b1) $display("FAIL mark_held: got y=%b z=%b want 1/1", pb_y, pb_z);
        else passed++;
        we1 = 1'b1; rw1 = 4'd7; bus_w1 = 32'h5;
        step();
        total++;
        if (pb_y !== 1'b0 || b_y !== 32'h5) $display("FAIL write_clears_bypass: got %b/%h want 0/5", pb_y, b_y);
        else passed++;
        total++;
        if (pb_z !== 1'b1 || b_z !== 32'h0) $display("FAIL write_clears_prior: got %b/%h want 1/0", pb_z, b_z);
        else passed++;
        idle();
        step();
        total++;
        if (pb_z !== 1'b0 || b_z !== 32'h5) $display("FAIL write_clears_stored: got %b/%h want 0/5", pb_z, b_z);
        else passed++;
        mark_en = 1'b1; mark_addr = 4'd7;
        we0 = 1'b1; rw0 = 4'd7; bus_w0 = 32'h9;
        step();
        total++;
        if (pb_y !== 1'b1 || b_y !== 32'h9) $display("FAIL mark_beats_write_bypass: got %b/%h want 1/9", pb_y, b_y);
        else passed++;
        idle();
        step();
        total++;
        if (pb_z !== 1'b1 || b_z !== 32'h9 || pb_y !== 1'b1)
            $display("FAIL mark_beats_write: got z=%b/%h y=%b want 1/9 1", pb_z, b_z, pb_y);
        else passed++;
    endtask

    task automatic test_zero_r0();
        ra = 4'd0;
        we0 = 1'b1; rw0 = 4'd0; bus_w0 = 32'hFFFF;
        mark_en = 1'b1; mark_addr = 4'd0;
        step();
        total++;
        if (a_y !== 32'hFFFF || pa_y !== 1'b1) $display("FAIL r0_normal: got %h/%b want ffff/1", a_y, pa_y);
        else passed++;
        total++;
        if (a_z !== 32'h0 || pa_z !== 1'b0) $display("FAIL r0_zero_now: got %h/%b want 0/0", a_z, pa_z);
        else passed++;
        idle();
        step();
        total++;
        if (a_z !== 32'h0 || pa_z !== 1'b0) $display("FAIL r0_zero_later: got %h/%b want 0/0", a_z, pa_z);
        else passed++;
        we0 = 1'b1; rw0 = 4'd0; bus_w0 = 32'h1;
        we1 = 1'b1; rw1 = 4'd0; bus_w1 = 32'h2;
        step();
        total++;
        if (col_z !== 1'b1 || col_y !== 1'b1) $display("FAIL r0_collide: got y=%b z=%b want 1", col_y, col_z);
        else passed++;
        idle();
        step();
        total++;
        if (a_z !== 32'h0 || col_z !== 1'b0) $display("FAIL r0_after_collide: got %h/%b want 0/0", a_z, col_z);
        else passed++;
    endtask

    task automatic test_rd_hold();
        ra = 4'd3; rd_en = 1'b1;
        step();
        rd_en = 1'b0;
        we0 = 1'b1; rw0 = 4'd3; bus_w0 = 32'h1234;
        step();
        idle();
        total++;
        if (a_y !== 32'hDEADBEEF || a_z !== 32'hDEADBEEF) $display("FAIL rd_hold: got y=%h z=%h want deadbeef", a_y, a_z);
        else passed++;
        step();
        total++;
        if (a_y !== 32'hDEADBEEF || a_z !== 32'hDEADBEEF) $display("FAIL rd_hold_2: got y=%h z=%h want deadbeef", a_y, a_z);
        else passed++;
        rd_en = 1'b1;
        step();
        total++;
        if (a_y !== 32'h1234 || a_z !== 32'h1234) $display("FAIL rd_resume: got y=%h z=%h want 1234", a_y, a_z);
        else passed++;
    endtask

    task automatic test_async_reset();
        for (int i = 1; i < 16; i++) begin
            we0 = 1'b1; rw0 = 4'(i); bus_w0 = i * 32'h01010101;
            mark_en = 1'b1; mark_addr = 4'(i);
            step();
        end
        idle();
        ra = 4'd15; rb = 4'd1;
        step();
        total++;
        if (a_y !== 32'h0F0F0F0F || b_z !== 32'h01010101 || pa_y !== 1'b1)
            $display("FAIL pre_reset_fill: got %h/%h/%b want 0f0f0f0f/01010101/1", a_y, b_z, pa_y);
        else passed++;
        #2;
        we0 = 1'b1; rw0 = 4'd4; bus_w0 = 32'hAAAA;
        rst = 1'b1;
        #1;
        total++;
        if ({a_y, b_y, pa_y, pb_y, col_y, a_z, b_z, pa_z, pb_z, col_z} !== '0)
            $display("FAIL async_reset_immediate: got y=%h/%h/%b%b%b z=%h/%h/%b%b%b want all 0",
                     a_y, b_y, pa_y, pb_y, col_y, a_z, b_z, pa_z, pb_z, col_z);
        else passed++;
        step();
        rst = 1'b0;
        idle();
        for (int i = 0; i < 16; i++) begin
            ra = 4'(i); rb = 4'(15 - i);
            step();
            total++;
            if ({a_y, b_y, pa_y, pb_y, a_z, b_z, pa_z, pb_z} !== '0)
                $display("FAIL post_reset_r%0d: got y=%h/%h/%b%b z=%h/%h/%b%b want all 0",
                         i, a_y, b_y, pa_y, pb_y, a_z, b_z, pa_z, pb_z);
            else passed++;
        end
    endtask

    initial begin
        test_reset();
        test_bypass();
        test_collide();
        test_scoreboard();
        test_zero_r0();
        test_rd_hold();
        test_async_reset();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/regfile_mp.md
# regfile_mp

Parametrised multi-port register file, successor to the processor's single-port-pair register file, used by the multicycle datapath between decode and execute. It has two independently enabled write ports for ALU/load results and base-register writeback, two registered read ports with optional write-to-read bypass, and a per-register pending scoreboard for in-flight results. All storage and outputs are cleared by an asynchronous reset.

## Interface
- DATA_W, 32, register and bus width in bits
- ADDR_W, 4, register address width; register count NREGS = 2**ADDR_W
- ZERO_R0, 0, when 1 register 0 always reads 0, ignores writes and is never pending
- BYPASS, 1, when 1 a read of an address written in the same cycle returns the new data

Ports:
- clk  in  1  clock; all state changes on the rising edge
- rst  in  1  asynchronous, active-high reset
- rd_en  in  1  read enable; when 0, bus_a/bus_b/pend_a/pend_b hold their values
- ra  in  ADDR_W  read port A address
- rb  in  ADDR_W  read port B address
- bus_a  out  DATA_W  registered read data, port A
- bus_b  out  DATA_W  registered read data, port B
- pend_a  out  1  registered pending flag of ra, captured with bus_a
- pend_b  out  1  registered pending flag of rb, captured with bus_b
- we0  in  1  write enable, port 0 (primary result)
- rw0  in  ADDR_W  write address, port 0
- bus_w0  in  DATA_W  write data, port 0
- we1  in  1  write enable, port 1 (base-register writeback)
- rw1  in  ADDR_W  write address, port 1
- bus_w1  in  DATA_W  write data, port 1
- mark_en  in  1  set the pending bit of mark_addr
- mark_addr  in  ADDR_W  register to mark pending
- collide  out  1  registered pulse; 1 for one cycle after we0 and we1 targeted the same address

## Operation
- Storage: NREGS x DATA_W array plus NREGS pending bits.
- Writes: on the rising edge, if we0 then reg[rw0] <= bus_w0; if we1 then reg[rw1] <= bus_w1. Both ports may write different addresses in the same cycle.
- Write conflict: if we0 && we1 && rw0 == rw1, port 0 data is stored and collide is 1 in the next cycle. Otherwise collide is 0.
- Reads: when rd_en=1, bus_a <= value(ra) and bus_b <= value(rb) on the rising edge. Reads and writes proceed in the same cycle; unlike the previous block, a write never suppresses a read.
- value(x) with BYPASS=1 is the data written at this edge if x matches an enabled write address (port 0 over port 1 on a conflict), otherwise the stored value. With BYPASS=0 it is always the pre-edge stored value.
- Scoreboard: a write on either port clears pending[rw]; mark_en sets pending[mark_addr]. When a mark and a write hit the same address in the same cycle, the mark wins (new producer issued) and the bit ends at 1.
- pend_a/pend_b follow the same bypass rule as the data: with BYPASS=1 they reflect the post-edge pending bit; with BYPASS=0 they reflect the pre-edge bit.
- ZERO_R0=1: writes and marks to address 0 are ignored, reads of 0 return 0 and pending is 0, and a collision on address 0 still pulses collide.
- Addresses are always in range because NREGS = 2**ADDR_W, so there is no wrap-around case.

## Timing
- Read latency is 1 cycle: an address presented before edge N appears on bus_a/bus_b after edge N.
- Write-to-read latency is 0 extra cycles with BYPASS=1. With BYPASS=0 it is 1 extra cycle.
- collide is asserted in the cycle after the conflicting edge and lasts one cycle per conflicting edge.
- Reset (asserted at any time, including mid-write): all registers, pending bits, bus_a, bus_b, pend_a, pend_b and collide go to 0 immediately. No write completes while rst=1. The first edge after rst deasserts operates normally.
- rd_en=0 holds the read outputs but does not block writes or marks.

## Test plan
- Reset, then write we0 rw0=3 bus_w0=0xDEADBEEF and read ra=3 in the same cycle -> bus_a=0xDEADBEEF after that edge (BYPASS=1); with BYPASS=0, bus_a is 0, then 0xDEADBEEF one edge later.
- we0 rw0=5 bus_w0=0x11 with we1 rw1=5 bus_w1=0x22 -> reg5 reads 0x11 and collide=1 for exactly one cycle; with rw1=6, reg5=0x11, reg6=0x22 and collide=0.
- mark_en mark_addr=7, then read rb=7 -> pend_b=1; then we1 rw1=7 bus_w1=0x5 -> pend_b=0, bus_b=0x5; mark and write to 7 in the same cycle -> pending stays 1.
- ZERO_R0=1: we0 rw0=0 bus_w0=0xFFFF and mark 0 -> ra=0 reads bus_a=0 and pend_a=0.
- Hold rd_en=0 while writing new data to ra's register -> bus_a is unchanged; raise rd_en -> bus_a shows the new data.
- Assert rst asynchronously mid-cycle after writes to r1..r15 -> all outputs are 0 at once, and every register reads 0 after release.
